// File: rtl/vregs_pkg.sv
// Shared vector-register parameters, state encoding and the length-clamp helper
// used by the vector writeback path.
package vregs_pkg;

  localparam int NELEM = 16;
  localparam int EW    = 16;
  localparam int REG_W = 4;
  localparam int IDX_W = 4;
  localparam int LEN_W = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } wbState_e;

  // Oversized lengths collapse to a full register; result is the last element index.
  function automatic logic [IDX_W-1:0] lastIndex(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] lenClamp;
    if (len > LEN_W'(NELEM)) begin
      lenClamp = LEN_W'(NELEM);
    end else begin
      lenClamp = len;
    end
    return IDX_W'(lenClamp - 5'd1);
  endfunction

endpackage

// File: rtl/vwriteback_if.sv
// Result-offer handshake between the vector execute stage (master) and the
// writeback sequencer (slave).
interface vwriteback_if #(
  parameter int NELEM = vregs_pkg::NELEM,
  parameter int EW    = vregs_pkg::EW
);
  import vregs_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [REG_W-1:0]       in_addr;
  logic [LEN_W-1:0]       in_len;
  logic [NELEM*EW-1:0]    in_data;

  modport master (output in_valid, output in_addr, output in_len, output in_data, input in_ready);
  modport slave  (input in_valid, input in_addr, input in_len, input in_data, output in_ready);

endinterface

// File: rtl/vwriteback.sv
// Vector writeback sequencer: captures one vector result and streams it into the
// register file write port one element per cycle, accepting the next result on the last element.
module vwriteback #(
  parameter int NELEM = vregs_pkg::NELEM,
  parameter int EW    = vregs_pkg::EW
) (
  input  logic                       clk,
  input  logic                       rst,
  vwriteback_if.slave                bus,
  output logic                       wEn,
  output logic [vregs_pkg::REG_W-1:0] wAddr,
  output logic [vregs_pkg::IDX_W-1:0] wInd,
  output logic [EW-1:0]              wData,
  output logic                       busy,
  output logic [vregs_pkg::REG_W-1:0] pend_addr
);
  import vregs_pkg::*;

  wbState_e            state_r;
  logic [NELEM*EW-1:0] holdData_r;
  logic [IDX_W-1:0]    lastIdx_r;
  logic                inReady_r;

  logic                transfer_s;
  logic                loadNew_s;
  logic                atLast_s;
  logic [IDX_W-1:0]    nextInd_s;
  logic [IDX_W-1:0]    newLast_s;

  assign bus.in_ready = inReady_r;

  // Handshake decode and next-element index.
  always_comb begin
    transfer_s = bus.in_valid & inReady_r;
    nextInd_s  = wInd + 4'd1;
    newLast_s  = lastIndex(bus.in_len);
    if (transfer_s && (bus.in_len != 5'd0)) begin
      loadNew_s = 1'b1;
    end else begin
      loadNew_s = 1'b0;
    end
    if ((state_r == DRAIN) && (wInd == lastIdx_r)) begin
      atLast_s = 1'b1;
    end else begin
      atLast_s = 1'b0;
    end
  end

  // Holding copy of the accepted vector; only meaningful while draining.
  always_ff @(posedge clk) begin
    if (loadNew_s) begin
      holdData_r <= bus.in_data;
    end
  end

  // Drain FSM with registered write-port, status and ready outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      wEn       <= 1'b0;
      wAddr     <= 4'd0;
      wInd      <= 4'd0;
      wData     <= '0;
      busy      <= 1'b0;
      pend_addr <= 4'd0;
      lastIdx_r <= 4'd0;
      inReady_r <= 1'b1;
    end else if (loadNew_s) begin
      // Element 0 comes straight from the bus so a new vector starts without a bubble.
      state_r   <= DRAIN;
      wEn       <= 1'b1;
      wAddr     <= bus.in_addr;
      wInd      <= 4'd0;
      wData     <= bus.in_data[EW-1:0];
      busy      <= 1'b1;
      pend_addr <= bus.in_addr;
      lastIdx_r <= newLast_s;
      inReady_r <= (newLast_s == 4'd0);
    end else begin
      case (state_r)
        IDLE: begin
          wEn       <= 1'b0;
          busy      <= 1'b0;
          pend_addr <= 4'd0;
          inReady_r <= 1'b1;
        end
        DRAIN: begin
          if (atLast_s) begin
            state_r   <= IDLE;
            wEn       <= 1'b0;
            busy      <= 1'b0;
            pend_addr <= 4'd0;
            inReady_r <= 1'b1;
          end else begin
            wInd      <= nextInd_s;
            wData     <= holdData_r[int'(nextInd_s)*EW +: EW];
            inReady_r <= (nextInd_s == lastIdx_r);
          end
        end
        default: begin
          state_r   <= IDLE;
          wEn       <= 1'b0;
          busy      <= 1'b0;
          pend_addr <= 4'd0;
          inReady_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vwriteback.sv
// Directed bench for vwriteback with a register-file write-port model.
module tb_vwriteback;

  localparam int NE = 16;
  localparam int W  = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wEn;
  logic [3:0]   wAddr;
  logic [3:0]   wInd;
  logic [W-1:0] wData;
  logic         busy;
  logic [3:0]   pend_addr;

  logic         modelClr = 1'b1;
  logic [W-1:0] mem [16][NE];

  int errors = 0;
  int checks = 0;

  vwriteback_if #(.NELEM(NE), .EW(W)) bus ();

  vwriteback #(.NELEM(NE), .EW(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .wEn       (wEn),
    .wAddr     (wAddr),
    .wInd      (wInd),
    .wData     (wData),
    .busy      (busy),
    .pend_addr (pend_addr)
  );

  always #5 clk = ~clk;

  // Register file write port: a presented element lands on the following edge.
  always @(posedge clk) begin
    if (modelClr) begin
      for (int a = 0; a < 16; a++)
        for (int e = 0; e < NE; e++)
          mem[a][e] <= 16'hBEEF;
    end else if (wEn === 1'b1) begin
      mem[wAddr][wInd] <= wData;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic loadData(input logic [W-1:0] base);
    for (int i = 0; i < NE; i++)
      bus.in_data[i*W +: W] = base + 16'(i);
  endtask

  task automatic offer(input logic [3:0] addr, input logic [4:0] len, input logic [W-1:0] base);
    bus.in_valid = 1'b1;
    bus.in_addr  = addr;
    bus.in_len   = len;
    loadData(base);
  endtask

  initial begin
    int nWr;
    logic orderOk;
    bus.in_valid = 1'b0;
    bus.in_addr  = 4'd0;
    bus.in_len   = 5'd0;
    bus.in_data  = '0;

    // Reset values
    #2;
    check("rst_wEn", 32'(wEn), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pend", 32'(pend_addr), 32'd0);
    check("rst_wAddr", 32'(wAddr), 32'd0);
    check("rst_wInd", 32'(wInd), 32'd0);
    check("rst_wData", 32'(wData), 32'd0);
    step();
    step();
    rst = 1'b0;
    modelClr = 1'b0;
    step();
    check("rst_ready", 32'(bus.in_ready), 32'd1);

    // Full 16-element vector to reg 3, source data scrambled after transfer
    offer(4'd3, 5'd16, 16'h1000);
    step();
    bus.in_valid = 1'b0;
    bus.in_addr  = 4'hF;
    for (int i = 0; i < NE; i++) begin
      bus.in_data = {8{$urandom()}};
      check("a_wEn", 32'(wEn), 32'd1);
      check("a_wInd", 32'(wInd), 32'(i));
      check("a_wData", 32'(wData), 32'h1000 + 32'(i));
      check("a_wAddr", 32'(wAddr), 32'd3);
      check("a_pend", 32'(pend_addr), 32'd3);
      check("a_busy", 32'(busy), 32'd1);
      check("a_ready", 32'(bus.in_ready), (i == 15) ? 32'd1 : 32'd0);
      step();
    end
    check("a_end_wEn", 32'(wEn), 32'd0);
    check("a_end_busy", 32'(busy), 32'd0);
    check("a_end_pend", 32'(pend_addr), 32'd0);
    check("a_end_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < NE; i++)
      check("a_mem", 32'(mem[3][i]), 32'h1000 + 32'(i));

    // Back-to-back: reg 5 len 4, then reg 6 len 2 offered while draining
    offer(4'd5, 5'd4, 16'h0500);
    step();
    offer(4'd6, 5'd2, 16'h0600);
    for (int i = 0; i < 4; i++) begin
      check("b_wAddr", 32'(wAddr), 32'd5);
      check("b_wInd", 32'(wInd), 32'(i));
      check("b_wData", 32'(wData), 32'h0500 + 32'(i));
      check("b_ready", 32'(bus.in_ready), (i == 3) ? 32'd1 : 32'd0);
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    check("b2_wEn0", 32'(wEn), 32'd1);
    check("b2_wAddr0", 32'(wAddr), 32'd6);
    check("b2_wInd0", 32'(wInd), 32'd0);
    check("b2_wData0", 32'(wData), 32'h0600);
    check("b2_pend", 32'(pend_addr), 32'd6);
    check("b2_ready0", 32'(bus.in_ready), 32'd0);
    step();
    check("b2_wEn1", 32'(wEn), 32'd1);
    check("b2_wInd1", 32'(wInd), 32'd1);
    check("b2_wData1", 32'(wData), 32'h0601);
    check("b2_ready1", 32'(bus.in_ready), 32'd1);
    step();
    check("b2_end_wEn", 32'(wEn), 32'd0);
    check("b2_end_busy", 32'(busy), 32'd0);
    check("b_mem5_3", 32'(mem[5][3]), 32'h0503);
    check("b_mem6_1", 32'(mem[6][1]), 32'h0601);

    // Zero-length transfer is consumed silently
    offer(4'd7, 5'd0, 16'h0700);
    step();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      check("c_wEn", 32'(wEn), 32'd0);
      check("c_busy", 32'(busy), 32'd0);
      check("c_ready", 32'(bus.in_ready), 32'd1);
      step();
    end
    check("c_mem7", 32'(mem[7][0]), 32'hBEEF);

    // Reset in the middle of a drain of reg 9
    offer(4'd9, 5'd16, 16'h9000);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("d_wInd", 32'(wInd), 32'(i));
      if (i < 7) step();
    end
    rst = 1'b1;
    #1;
    check("d_rst_wEn", 32'(wEn), 32'd0);
    check("d_rst_busy", 32'(busy), 32'd0);
    check("d_rst_pend", 32'(pend_addr), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    check("d_post_wEn", 32'(wEn), 32'd0);
    check("d_post_ready", 32'(bus.in_ready), 32'd1);
    check("d_mem6", 32'(mem[9][6]), 32'h9006);
    for (int i = 8; i < NE; i++)
      check("d_mem_untouched", 32'(mem[9][i]), 32'hBEEF);

    // Oversized length is clamped to a full register
    offer(4'd10, 5'd20, 16'h0A00);
    step();
    bus.in_valid = 1'b0;
    nWr = 0;
    orderOk = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (wEn === 1'b1) begin
        if (wInd !== 4'(nWr)) orderOk = 1'b0;
        nWr++;
      end
      step();
    end
    check("e_count", 32'(nWr), 32'd16);
    check("e_order", 32'(orderOk), 32'd1);
    check("e_mem0", 32'(mem[10][0]), 32'h0A00);
    check("e_mem15", 32'(mem[10][15]), 32'h0A0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
